// File: rtl/csr_defines.sv
// Definitions shared by the commit-side exception logic and the CSR file:
// exception codes, controller state encoding and the per-slot commit record.
package csr_defines;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_IDLE_WAIT = 2'd1,
    ST_FLUSH     = 2'd2
  } exc_state_e;

  typedef enum logic [2:0] {
    EV_NONE = 3'd0,
    EV_INT  = 3'd1,
    EV_EXC  = 3'd2,
    EV_ERTN = 3'd3,
    EV_IDLE = 3'd4
  } exc_event_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        exc;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] badv;
    logic        tlb_exc;
    logic        inst_tlb_exc;
    logic        ertn;
    logic        idle;
  } slot_t;

  // TLB refill has its own vector; every other exception uses the common one.
  function automatic logic [31:0] exc_target(input logic [5:0]  ecode,
                                             input logic [31:0] eentry,
                                             input logic [31:0] tlbrentry);
    return (ecode == ECODE_TLBR) ? tlbrentry : eentry;
  endfunction

endpackage

// File: rtl/except_sel.sv
// Combinational priority selector over the two commit slots: picks the winning
// event, the slot that carries it, and which slots may retire this cycle.
module except_sel
  import csr_defines::*;
(
  input  slot_t       slot0_i,
  input  slot_t       slot1_i,
  input  logic        is_interrupt_i,
  output exc_event_e  event_o,
  output logic [31:0] pc_o,
  output logic [5:0]  ecode_o,
  output logic [8:0]  esubcode_o,
  output logic [31:0] badv_o,
  output logic        tlb_exc_o,
  output logic        inst_tlb_exc_o,
  output logic [1:0]  commit_mask_o
);

  slot_t      slots [2];
  logic [1:0] q_exc;
  logic [1:0] q_ertn;
  logic [1:0] q_idle;
  logic       sel_slot1;
  slot_t      sel;

  assign slots[0] = slot0_i;
  assign slots[1] = slot1_i;

  // Flags of an empty slot are meaningless and must never win.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_qual
      assign q_exc[gi]  = slots[gi].valid & slots[gi].exc;
      assign q_ertn[gi] = slots[gi].valid & slots[gi].ertn;
      assign q_idle[gi] = slots[gi].valid & slots[gi].idle;
    end
  endgenerate

  always_comb begin
    event_o       = EV_NONE;
    sel_slot1     = 1'b0;
    commit_mask_o = {slot1_i.valid, slot0_i.valid};
    if (is_interrupt_i && slot0_i.valid) begin
      event_o       = EV_INT;
      commit_mask_o = 2'b00;
    end else if (q_exc[0]) begin
      event_o       = EV_EXC;
      commit_mask_o = 2'b00;
    end else if (q_ertn[0]) begin
      event_o       = EV_ERTN;
      commit_mask_o = 2'b01;
    end else if (q_idle[0]) begin
      event_o       = EV_IDLE;
      commit_mask_o = 2'b01;
    end else if (q_exc[1]) begin
      event_o       = EV_EXC;
      sel_slot1     = 1'b1;
      commit_mask_o = {1'b0, slot0_i.valid};
    end else if (q_ertn[1]) begin
      event_o       = EV_ERTN;
      sel_slot1     = 1'b1;
      commit_mask_o = {1'b1, slot0_i.valid};
    end else if (q_idle[1]) begin
      event_o       = EV_IDLE;
      sel_slot1     = 1'b1;
      commit_mask_o = {1'b1, slot0_i.valid};
    end
  end

  assign sel            = sel_slot1 ? slot1_i : slot0_i;
  assign pc_o           = sel.pc;
  assign ecode_o        = sel.ecode;
  assign esubcode_o     = sel.esubcode;
  assign badv_o         = sel.badv;
  assign tlb_exc_o      = sel.tlb_exc;
  assign inst_tlb_exc_o = sel.inst_tlb_exc;

endmodule

// File: rtl/except_ctrl.sv
// Commit-stage exception controller: turns slot events into one-cycle CSR
// update / flush / redirect pulses and parks the core while IDLE waits.
module except_ctrl
  import csr_defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        slot0_valid,
  input  logic [31:0] slot0_pc,
  input  logic        slot0_exc,
  input  logic [5:0]  slot0_ecode,
  input  logic [8:0]  slot0_esubcode,
  input  logic [31:0] slot0_badv,
  input  logic        slot0_tlb_exc,
  input  logic        slot0_inst_tlb_exc,
  input  logic        slot0_ertn,
  input  logic        slot0_idle,
  input  logic        slot1_valid,
  input  logic [31:0] slot1_pc,
  input  logic        slot1_exc,
  input  logic [5:0]  slot1_ecode,
  input  logic [8:0]  slot1_esubcode,
  input  logic [31:0] slot1_badv,
  input  logic        slot1_tlb_exc,
  input  logic        slot1_inst_tlb_exc,
  input  logic        slot1_ertn,
  input  logic        slot1_idle,
  input  logic [31:0] eentry,
  input  logic [31:0] tlbrentry,
  input  logic [31:0] era,
  input  logic        is_interrupt,
  output logic        is_exception,
  output logic [31:0] exception_pc,
  output logic [31:0] exception_addr,
  output logic [5:0]  ecode,
  output logic [8:0]  esubcode,
  output logic        is_tlb_exception,
  output logic        is_inst_tlb_exception,
  output logic        is_ertn,
  output logic        flush,
  output logic        redirect_en,
  output logic [31:0] redirect_pc,
  output logic [1:0]  commit_mask,
  output logic        stall_idle
);

  slot_t       slot0;
  slot_t       slot1;
  exc_event_e  sel_event;
  logic [31:0] sel_pc;
  logic [5:0]  sel_ecode;
  logic [8:0]  sel_esubcode;
  logic [31:0] sel_badv;
  logic        sel_tlb_exc;
  logic        sel_inst_tlb_exc;
  logic [1:0]  sel_mask;

  exc_state_e  state_q, state_d;
  logic [31:0] idle_pc_q, idle_pc_d;
  logic        is_exception_q, is_exception_d;
  logic [31:0] exception_pc_q, exception_pc_d;
  logic [31:0] exception_addr_q, exception_addr_d;
  logic [5:0]  ecode_q, ecode_d;
  logic [8:0]  esubcode_q, esubcode_d;
  logic        tlb_q, tlb_d;
  logic        inst_tlb_q, inst_tlb_d;
  logic        is_ertn_q, is_ertn_d;
  logic        flush_q, flush_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  assign slot0 = '{valid: slot0_valid, pc: slot0_pc, exc: slot0_exc,
                   ecode: slot0_ecode, esubcode: slot0_esubcode,
                   badv: slot0_badv, tlb_exc: slot0_tlb_exc,
                   inst_tlb_exc: slot0_inst_tlb_exc, ertn: slot0_ertn,
                   idle: slot0_idle};
  assign slot1 = '{valid: slot1_valid, pc: slot1_pc, exc: slot1_exc,
                   ecode: slot1_ecode, esubcode: slot1_esubcode,
                   badv: slot1_badv, tlb_exc: slot1_tlb_exc,
                   inst_tlb_exc: slot1_inst_tlb_exc, ertn: slot1_ertn,
                   idle: slot1_idle};

  except_sel u_sel (
    .slot0_i        (slot0),
    .slot1_i        (slot1),
    .is_interrupt_i (is_interrupt),
    .event_o        (sel_event),
    .pc_o           (sel_pc),
    .ecode_o        (sel_ecode),
    .esubcode_o     (sel_esubcode),
    .badv_o         (sel_badv),
    .tlb_exc_o      (sel_tlb_exc),
    .inst_tlb_exc_o (sel_inst_tlb_exc),
    .commit_mask_o  (sel_mask)
  );

  always_comb begin
    state_d          = state_q;
    idle_pc_d        = idle_pc_q;
    is_exception_d   = 1'b0;
    exception_pc_d   = '0;
    exception_addr_d = '0;
    ecode_d          = '0;
    esubcode_d       = '0;
    tlb_d            = 1'b0;
    inst_tlb_d       = 1'b0;
    is_ertn_d        = 1'b0;
    redirect_pc_d    = '0;
    commit_mask      = 2'b00;

    case (state_q)
      ST_RUN: begin
        commit_mask = sel_mask;
        case (sel_event)
          EV_INT: begin
            is_exception_d = 1'b1;
            exception_pc_d = slot0_pc;
            ecode_d        = ECODE_INT;
            redirect_pc_d  = eentry;
            state_d        = ST_FLUSH;
          end
          EV_EXC: begin
            is_exception_d   = 1'b1;
            exception_pc_d   = sel_pc;
            exception_addr_d = sel_badv;
            ecode_d          = sel_ecode;
            esubcode_d       = sel_esubcode;
            tlb_d            = sel_tlb_exc;
            inst_tlb_d       = sel_inst_tlb_exc;
            redirect_pc_d    = exc_target(sel_ecode, eentry, tlbrentry);
            state_d          = ST_FLUSH;
          end
          EV_ERTN: begin
            is_ertn_d     = 1'b1;
            redirect_pc_d = era;
            state_d       = ST_FLUSH;
          end
          EV_IDLE: begin
            idle_pc_d = sel_pc + 32'd4;
            state_d   = ST_IDLE_WAIT;
          end
          default: ;
        endcase
      end
      // The wake-up interrupt returns to the instruction after IDLE.
      ST_IDLE_WAIT: begin
        if (is_interrupt) begin
          is_exception_d = 1'b1;
          exception_pc_d = idle_pc_q;
          ecode_d        = ECODE_INT;
          redirect_pc_d  = eentry;
          state_d        = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    if (!rst) commit_mask = 2'b00;
  end

  assign flush_d = is_exception_d | is_ertn_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_RUN;
      idle_pc_q        <= '0;
      is_exception_q   <= 1'b0;
      exception_pc_q   <= '0;
      exception_addr_q <= '0;
      ecode_q          <= '0;
      esubcode_q       <= '0;
      tlb_q            <= 1'b0;
      inst_tlb_q       <= 1'b0;
      is_ertn_q        <= 1'b0;
      flush_q          <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      idle_pc_q        <= idle_pc_d;
      is_exception_q   <= is_exception_d;
      exception_pc_q   <= exception_pc_d;
      exception_addr_q <= exception_addr_d;
      ecode_q          <= ecode_d;
      esubcode_q       <= esubcode_d;
      tlb_q            <= tlb_d;
      inst_tlb_q       <= inst_tlb_d;
      is_ertn_q        <= is_ertn_d;
      flush_q          <= flush_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign is_exception          = is_exception_q;
  assign exception_pc          = exception_pc_q;
  assign exception_addr        = exception_addr_q;
  assign ecode                 = ecode_q;
  assign esubcode              = esubcode_q;
  assign is_tlb_exception      = tlb_q;
  assign is_inst_tlb_exception = inst_tlb_q;
  assign is_ertn               = is_ertn_q;
  assign flush                 = flush_q;
  assign redirect_en           = flush_q;
  assign redirect_pc           = redirect_pc_q;
  assign stall_idle            = (state_q == ST_IDLE_WAIT);

endmodule

// File: tb/tb_except_ctrl.sv
// Directed bench for except_ctrl: a cycle-level reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_except_ctrl;

  logic        clk, rst;
  logic        slot0_valid, slot0_exc, slot0_tlb_exc, slot0_inst_tlb_exc, slot0_ertn, slot0_idle;
  logic        slot1_valid, slot1_exc, slot1_tlb_exc, slot1_inst_tlb_exc, slot1_ertn, slot1_idle;
  logic [31:0] slot0_pc, slot0_badv, slot1_pc, slot1_badv;
  logic [5:0]  slot0_ecode, slot1_ecode;
  logic [8:0]  slot0_esubcode, slot1_esubcode;
  logic [31:0] eentry, tlbrentry, era;
  logic        is_interrupt;
  logic        is_exception, is_tlb_exception, is_inst_tlb_exception, is_ertn;
  logic [31:0] exception_pc, exception_addr, redirect_pc;
  logic [5:0]  ecode;
  logic [8:0]  esubcode;
  logic        flush, redirect_en, stall_idle;
  logic [1:0]  commit_mask;

  int n_checks = 0;
  int n_fail   = 0;

  except_ctrl dut (
    .clk(clk), .rst(rst),
    .slot0_valid(slot0_valid), .slot0_pc(slot0_pc), .slot0_exc(slot0_exc),
    .slot0_ecode(slot0_ecode), .slot0_esubcode(slot0_esubcode), .slot0_badv(slot0_badv),
    .slot0_tlb_exc(slot0_tlb_exc), .slot0_inst_tlb_exc(slot0_inst_tlb_exc),
    .slot0_ertn(slot0_ertn), .slot0_idle(slot0_idle),
    .slot1_valid(slot1_valid), .slot1_pc(slot1_pc), .slot1_exc(slot1_exc),
    .slot1_ecode(slot1_ecode), .slot1_esubcode(slot1_esubcode), .slot1_badv(slot1_badv),
    .slot1_tlb_exc(slot1_tlb_exc), .slot1_inst_tlb_exc(slot1_inst_tlb_exc),
    .slot1_ertn(slot1_ertn), .slot1_idle(slot1_idle),
    .eentry(eentry), .tlbrentry(tlbrentry), .era(era), .is_interrupt(is_interrupt),
    .is_exception(is_exception), .exception_pc(exception_pc), .exception_addr(exception_addr),
    .ecode(ecode), .esubcode(esubcode), .is_tlb_exception(is_tlb_exception),
    .is_inst_tlb_exception(is_inst_tlb_exception), .is_ertn(is_ertn),
    .flush(flush), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .commit_mask(commit_mask), .stall_idle(stall_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Mode flags: waiting for wake-up, or in the single ignored cycle after a pulse.
  logic        m_wait, m_flushing;
  logic [31:0] m_resume;
  logic        e_exc, e_ertn, e_tlb, e_itlb;
  logic [31:0] e_pc, e_addr, e_rpc;
  logic [5:0]  e_ecode;
  logic [8:0]  e_esub;

  // Index of the first true condition in priority order; 7 means no event.
  function automatic int winner();
    logic [6:0] c;
    c[0] = is_interrupt & slot0_valid;
    c[1] = slot0_valid & slot0_exc;
    c[2] = slot0_valid & slot0_ertn;
    c[3] = slot0_valid & slot0_idle;
    c[4] = slot1_valid & slot1_exc;
    c[5] = slot1_valid & slot1_ertn;
    c[6] = slot1_valid & slot1_idle;
    for (int i = 0; i < 7; i++) if (c[i]) return i;
    return 7;
  endfunction

  function automatic logic [1:0] exp_mask();
    int k;
    if (!rst || m_wait || m_flushing) return 2'b00;
    k = winner();
    case (k)
      0, 1:    return 2'b00;
      2, 3:    return 2'b01;
      4:       return {1'b0, slot0_valid};
      5, 6:    return {1'b1, slot0_valid};
      default: return {slot1_valid, slot0_valid};
    endcase
  endfunction

  task automatic model_clear();
    m_wait = 0; m_flushing = 0; m_resume = 0;
    e_exc = 0; e_ertn = 0; e_tlb = 0; e_itlb = 0;
    e_pc = 0; e_addr = 0; e_rpc = 0; e_ecode = 0; e_esub = 0;
  endtask

  task automatic model_step();
    int  k;
    logic s1;
    logic n_exc = 0, n_ertn = 0, n_tlb = 0, n_itlb = 0;
    logic [31:0] n_pc = 0, n_addr = 0, n_rpc = 0;
    logic [5:0]  n_ecode = 0;
    logic [8:0]  n_esub = 0;
    if (m_flushing) begin
      m_flushing = 0;
    end else if (m_wait) begin
      if (is_interrupt) begin
        n_exc = 1; n_pc = m_resume; n_rpc = eentry;
        m_wait = 0; m_flushing = 1;
      end
    end else begin
      k  = winner();
      s1 = (k >= 4);
      if (k == 0) begin
        n_exc = 1; n_pc = slot0_pc; n_rpc = eentry; m_flushing = 1;
      end else if (k == 1 || k == 4) begin
        n_exc   = 1;
        n_pc    = s1 ? slot1_pc : slot0_pc;
        n_addr  = s1 ? slot1_badv : slot0_badv;
        n_ecode = s1 ? slot1_ecode : slot0_ecode;
        n_esub  = s1 ? slot1_esubcode : slot0_esubcode;
        n_tlb   = s1 ? slot1_tlb_exc : slot0_tlb_exc;
        n_itlb  = s1 ? slot1_inst_tlb_exc : slot0_inst_tlb_exc;
        n_rpc   = (n_ecode == 6'h3F) ? tlbrentry : eentry;
        m_flushing = 1;
      end else if (k == 2 || k == 5) begin
        n_ertn = 1; n_rpc = era; m_flushing = 1;
      end else if (k == 3 || k == 6) begin
        m_wait = 1; m_resume = (s1 ? slot1_pc : slot0_pc) + 32'd4;
      end
    end
    e_exc = n_exc; e_ertn = n_ertn; e_tlb = n_tlb; e_itlb = n_itlb;
    e_pc = n_pc; e_addr = n_addr; e_rpc = n_rpc; e_ecode = n_ecode; e_esub = n_esub;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_clear();
      else      model_step();
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("cmp_is_exception", {31'd0, is_exception}, {31'd0, e_exc});
      check("cmp_is_ertn", {31'd0, is_ertn}, {31'd0, e_ertn});
      check("cmp_flush", {31'd0, flush}, {31'd0, e_exc | e_ertn});
      check("cmp_redirect_en", {31'd0, redirect_en}, {31'd0, e_exc | e_ertn});
      check("cmp_exception_pc", exception_pc, e_pc);
      check("cmp_exception_addr", exception_addr, e_addr);
      check("cmp_ecode", {26'd0, ecode}, {26'd0, e_ecode});
      check("cmp_esubcode", {23'd0, esubcode}, {23'd0, e_esub});
      check("cmp_tlb", {30'd0, is_tlb_exception, is_inst_tlb_exception}, {30'd0, e_tlb, e_itlb});
      check("cmp_redirect_pc", redirect_pc, e_rpc);
      check("cmp_stall_idle", {31'd0, stall_idle}, {31'd0, m_wait});
      check("cmp_commit_mask", {30'd0, commit_mask}, {30'd0, exp_mask()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  task automatic clear_slots();
    slot0_valid = 0; slot0_pc = 0; slot0_exc = 0; slot0_ecode = 0; slot0_esubcode = 0;
    slot0_badv = 0; slot0_tlb_exc = 0; slot0_inst_tlb_exc = 0; slot0_ertn = 0; slot0_idle = 0;
    slot1_valid = 0; slot1_pc = 0; slot1_exc = 0; slot1_ecode = 0; slot1_esubcode = 0;
    slot1_badv = 0; slot1_tlb_exc = 0; slot1_inst_tlb_exc = 0; slot1_ertn = 0; slot1_idle = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic plain_pair(input logic [31:0] pc);
    clear_slots();
    slot0_valid = 1; slot0_pc = pc; slot1_valid = 1; slot1_pc = pc + 32'd4;
  endtask

  initial begin
    rst = 0; is_interrupt = 0;
    eentry = 32'h1C008000; tlbrentry = 32'h1C00F000; era = 32'h1C000040;
    plain_pair(32'h1C000000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_mask", {30'd0, commit_mask}, 32'd0);
    check("reset_flush", {31'd0, flush}, 32'd0);
    $display("txn reset       mask=%b flush=%b", commit_mask, flush);

    next_cycle(); rst = 1;
    @(negedge clk);
    check("run_no_event_mask", {30'd0, commit_mask}, 32'd3);
    $display("txn no_event    mask=%b", commit_mask);

    // slot0 SYS exception; slot1 younger and squashed
    next_cycle(); plain_pair(32'h1C000100);
    slot0_exc = 1; slot0_ecode = 6'h0B;
    @(negedge clk);
    check("sys_mask", {30'd0, commit_mask}, 32'd0);
    next_cycle(); plain_pair(32'h1C000180); slot0_exc = 1;
    @(negedge clk);
    check("sys_is_exception", {31'd0, is_exception}, 32'd1);
    check("sys_exception_pc", exception_pc, 32'h1C000100);
    check("sys_redirect_pc", redirect_pc, 32'h1C008000);
    check("sys_flush_mask", {30'd0, commit_mask}, 32'd0);
    $display("txn sys         exc=%b pc=%h rpc=%h ecode=%h", is_exception, exception_pc, redirect_pc, ecode);
    next_cycle(); clear_slots();
    @(negedge clk);
    check("sys_pulse_end", {31'd0, is_exception}, 32'd0);

    // slot1 TLB refill behind a clean slot0
    next_cycle(); plain_pair(32'h1C000300);
    slot1_exc = 1; slot1_ecode = 6'h3F; slot1_badv = 32'h00401000; slot1_tlb_exc = 1;
    @(negedge clk);
    check("tlbr_mask", {30'd0, commit_mask}, 32'd1);
    next_cycle(); clear_slots();
    @(negedge clk);
    check("tlbr_addr", exception_addr, 32'h00401000);
    check("tlbr_redirect_pc", redirect_pc, 32'h1C00F000);
    check("tlbr_pc", exception_pc, 32'h1C000304);
    $display("txn tlbr        addr=%h rpc=%h ecode=%h tlb=%b", exception_addr, redirect_pc, ecode, is_tlb_exception);

    // ERTN in slot0
    next_cycle(); plain_pair(32'h1C000400); slot0_ertn = 1;
    @(negedge clk);
    check("ertn_mask", {30'd0, commit_mask}, 32'd1);
    next_cycle(); clear_slots();
    @(negedge clk);
    check("ertn_is_ertn", {31'd0, is_ertn}, 32'd1);
    check("ertn_is_exception", {31'd0, is_exception}, 32'd0);
    check("ertn_redirect_pc", redirect_pc, 32'h1C000040);
    $display("txn ertn        ertn=%b exc=%b rpc=%h", is_ertn, is_exception, redirect_pc);

    // IDLE in slot0, interrupt arrives in the fifth wait cycle
    next_cycle(); plain_pair(32'h1C000200); slot0_idle = 1;
    @(negedge clk);
    check("idle_mask", {30'd0, commit_mask}, 32'd1);
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      plain_pair(32'h1C000900 + 32'(i * 8));
      is_interrupt = (i == 4);
      @(negedge clk);
      check("idle_stall", {31'd0, stall_idle}, 32'd1);
      check("idle_wait_mask", {30'd0, commit_mask}, 32'd0);
      next_cycle();
    end
    is_interrupt = 0; clear_slots();
    @(negedge clk);
    check("idle_wake_pc", exception_pc, 32'h1C000204);
    check("idle_wake_ecode", {26'd0, ecode}, 32'd0);
    check("idle_wake_exc", {31'd0, is_exception}, 32'd1);
    check("idle_stall_off", {31'd0, stall_idle}, 32'd0);
    $display("txn idle_wake   exc=%b pc=%h ecode=%h", is_exception, exception_pc, ecode);

    // interrupt and slot0 exception together: interrupt wins
    next_cycle(); plain_pair(32'h1C000500);
    slot0_exc = 1; slot0_ecode = 6'h0B; slot0_badv = 32'h00001234; is_interrupt = 1;
    @(negedge clk);
    check("int_mask", {30'd0, commit_mask}, 32'd0);
    next_cycle(); clear_slots(); is_interrupt = 0;
    @(negedge clk);
    check("int_ecode", {26'd0, ecode}, 32'd0);
    check("int_pc", exception_pc, 32'h1C000500);
    check("int_addr", exception_addr, 32'd0);
    $display("txn int_vs_exc  exc=%b pc=%h ecode=%h", is_exception, exception_pc, ecode);

    // invalid slots: their flags and the interrupt must not fire
    next_cycle(); clear_slots();
    slot0_exc = 1; slot0_ertn = 1; slot1_exc = 1; slot1_idle = 1; is_interrupt = 1;
    @(negedge clk);
    check("invalid_mask", {30'd0, commit_mask}, 32'd0);
    next_cycle(); clear_slots(); is_interrupt = 0;
    @(negedge clk);
    check("invalid_no_pulse", {31'd0, flush}, 32'd0);
    $display("txn invalid     flush=%b", flush);

    // IDLE in slot1 retires both slots; immediate wake-up
    next_cycle(); plain_pair(32'h1C000700); slot1_idle = 1;
    @(negedge clk);
    check("idle1_mask", {30'd0, commit_mask}, 32'd3);
    next_cycle(); clear_slots(); is_interrupt = 1;
    @(negedge clk);
    next_cycle(); is_interrupt = 0;
    @(negedge clk);
    check("idle1_wake_pc", exception_pc, 32'h1C000708);
    $display("txn idle_slot1  pc=%h", exception_pc);

    // slot1 ERTN
    next_cycle(); plain_pair(32'h1C000A00); slot1_ertn = 1; era = 32'h1C000A80;
    @(negedge clk);
    check("ertn1_mask", {30'd0, commit_mask}, 32'd3);
    next_cycle(); clear_slots();
    @(negedge clk);
    check("ertn1_redirect_pc", redirect_pc, 32'h1C000A80);
    $display("txn ertn_slot1  rpc=%h", redirect_pc);

    // reset asserted during FLUSH drops the pulse
    next_cycle(); plain_pair(32'h1C000600); slot0_exc = 1; slot0_ecode = 6'h08;
    next_cycle(); clear_slots();
    #1 rst = 0;
    #1;
    check("rst_flush_exc", {31'd0, is_exception}, 32'd0);
    check("rst_flush_flush", {31'd0, flush}, 32'd0);
    check("rst_flush_rpc", redirect_pc, 32'd0);
    next_cycle(); rst = 1; plain_pair(32'h1C000B00);
    @(negedge clk);
    check("rst_flush_run_mask", {30'd0, commit_mask}, 32'd3);
    $display("txn rst_flush   mask=%b", commit_mask);

    // reset asserted during IDLE_WAIT forgets the idle
    next_cycle(); plain_pair(32'h1C000800); slot0_idle = 1;
    next_cycle(); clear_slots();
    #1 rst = 0;
    #1;
    check("rst_wait_stall", {31'd0, stall_idle}, 32'd0);
    next_cycle(); rst = 1; is_interrupt = 1;
    @(negedge clk);
    next_cycle(); is_interrupt = 0;
    @(negedge clk);
    check("rst_wait_no_wake", {31'd0, is_exception}, 32'd0);
    $display("txn rst_wait    exc=%b stall=%b", is_exception, stall_idle);

    next_cycle();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
